vga_timing_core: RTL

Parametrised single-clock VGA/raster timing generator, successor to the fixed 640x480 timing block. Horizontal and vertical counters run in the same clock domain. A pixel clock-enable sets the advance rate. Outputs are registered: sync with programmable polarity, blanking, active-region-relative coordinates, and one-cycle line, frame and last-pixel strobes. It sits between the system clock and the pixel pipeline / framebuffer reader, which treat x/y/active as the pixel request for the current cycle.

---
 rtl/vga_timing_core.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised single-clock raster timing generator.
//
// Counters h_cnt/v_cnt advance on clock edges where ce_i is high. A line is laid out
// from count 0 as sync, back porch, active, front porch; frames use the same ordering.
// All outputs are registered and describe the counter values consumed on the enabled
// edge that loaded them, so they lag the counters by one clock.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous reset, active-high
//   ce_i           pixel advance enable
//   hsync_o        horizontal sync, level HS_POL during sync
//   vsync_o        vertical sync, level VS_POL during sync
//   active_o       visible pixel
//   hblank_o       outside horizontal active region
//   vblank_o       outside vertical active region
//   x_o            column within active region (0 while horizontally blanked)
//   y_o            row within active region (0 while vertically blanked)
//   line_start_o   one-clock strobe for the first pixel period of every line
//   frame_start_o  one-clock strobe for the first pixel period of every frame
//   last_pixel_o   one-clock strobe for the final visible pixel of the frame
//   frame_count_o  frame counter
//
// Build option: define VGA_TIMING_FRAME_CNT_EN to enable the frame counter. Without it
// frame_count_o is tied to zero and no counter register is built.

module vga_timing_core #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CW       = 10,
   parameter int unsigned FCW      = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           ce_i,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic           active_o,
   output logic           hblank_o,
   output logic           vblank_o,
   output logic [CW-1:0]  x_o,
   output logic [CW-1:0]  y_o,
   output logic           line_start_o,
   output logic           frame_start_o,
   output logic           last_pixel_o,
   output logic [FCW-1:0] frame_count_o
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned HA0     = H_SYNC + H_BP;
   localparam int unsigned VA0     = V_SYNC + V_BP;
   localparam int unsigned HA_END  = HA0 + H_ACTIVE;
   localparam int unsigned VA_END  = VA0 + V_ACTIVE;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] HA0_CW = CW'(HA0);
   localparam logic [CW-1:0] VA0_CW = CW'(VA0);
   localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

   logic [CW-1:0] h_cnt_q, h_cnt_d;
   logic [CW-1:0] v_cnt_q, v_cnt_d;

   // Counter next state
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (ce_i) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
         end else begin
            h_cnt_d = h_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Decode of the pre-increment counters. Range checks are done at 32 bits so an
   // active region ending exactly at 2^CW cannot overflow.
   logic [31:0]   h_ext, v_ext;
   logic          h_in, v_in;
   logic          hsync_d, vsync_d, active_d;
   logic [CW-1:0] x_d, y_d;
   logic          line_start_d, frame_start_d, last_pixel_d;

   always_comb begin
      h_ext         = 32'(h_cnt_q);
      v_ext         = 32'(v_cnt_q);
      h_in          = (h_ext >= HA0) && (h_ext < HA_END);
      v_in          = (v_ext >= VA0) && (v_ext < VA_END);
      hsync_d       = (h_ext < H_SYNC) ? HS_POL : ~HS_POL;
      vsync_d       = (v_ext < V_SYNC) ? VS_POL : ~VS_POL;
      active_d      = h_in && v_in;
      x_d           = h_in ? (h_cnt_q - HA0_CW) : '0;
      y_d           = v_in ? (v_cnt_q - VA0_CW) : '0;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = line_start_d && (v_cnt_q == '0);
      last_pixel_d  = active_d && (x_d == X_LAST) && (y_d == Y_LAST);
   end

   // Level outputs hold while ce_i is low; strobes clear so each lasts one clock.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hsync_o       <= ~HS_POL;
         vsync_o       <= ~VS_POL;
         active_o      <= 1'b0;
         hblank_o      <= 1'b1;
         vblank_o      <= 1'b1;
         x_o           <= '0;
         y_o           <= '0;
         line_start_o  <= 1'b0;
         frame_start_o <= 1'b0;
         last_pixel_o  <= 1'b0;
      end else if (ce_i) begin
         hsync_o       <= hsync_d;
         vsync_o       <= vsync_d;
         active_o      <= active_d;
         hblank_o      <= ~h_in;
         vblank_o      <= ~v_in;
         x_o           <= x_d;
         y_o           <= y_d;
         line_start_o  <= line_start_d;
         frame_start_o <= frame_start_d;
         last_pixel_o  <= last_pixel_d;
      end else begin
         line_start_o  <= 1'b0;
         frame_start_o <= 1'b0;
         last_pixel_o  <= 1'b0;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FCW-1:0] frame_cnt_q;

   // Advances on the same edge that raises frame_start_o, so frame 1 reads 1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frame_cnt_q <= '0;
      end else if (ce_i && frame_start_d) begin
         frame_cnt_q <= frame_cnt_q + FCW'(1);
      end
   end

   assign frame_count_o = frame_cnt_q;
`else
   assign frame_count_o = '0;
`endif

endmodule
